// File: rtl/traffic_request_conditioner.sv
// traffic_request_conditioner: conditions raw walk button / vehicle sensor pins
// into clean walkButton / Sensor levels for traffic_light and counts served requests.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-low reset
//   walk_btn_raw  in   raw pedestrian button pin (async, bouncy)
//   sensor_raw    in   raw vehicle sensor pin (async, bouncy)
//   walkLight     in   walk indication from traffic_light, acts as request acknowledge
//   walkButton    out  latched walk request (high while in REQ)
//   Sensor        out  debounced vehicle-present level
//   served_count  out  acknowledged requests, saturating at 255
//   walk_timeout  out  one-cycle pulse when a request is abandoned
//
// Optional feature: define WALK_TIMEOUT_EN to abandon a request after
// TIMEOUT_CYCLES cycles in REQ without acknowledge.

module traffic_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       walk_btn_raw,
    input  logic       sensor_raw,
    input  logic       walkLight,
    output logic       walkButton,
    output logic       Sensor,
    output logic [7:0] served_count,
    output logic       walk_timeout
);

    localparam int DBW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is the walk button, bit 1 the vehicle sensor.
    localparam int BTN = 0;
    localparam int SNS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } state_t;

    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [1:0]          deb_q, deb_d;
    logic [1:0][DBW-1:0] dcnt_q, dcnt_d;
    logic                btn_prev_q, btn_prev_d;
    state_t              state_q, state_d;
    logic [7:0]          served_q, served_d;
    logic                press;

    // ---------------- synchronizer + debounce ----------------
    always_comb begin
        sync1_d    = {sensor_raw, walk_btn_raw};
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        dcnt_d     = '0;
        btn_prev_d = deb_q[BTN];
        for (int i = 0; i < 2; i++) begin
            // Any cycle where synced and debounced agree restarts the count.
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A held button yields one press; a new one needs a debounced release.
    assign press = deb_q[BTN] & ~btn_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            dcnt_q     <= '0;
            btn_prev_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            dcnt_q     <= dcnt_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    // ---------------- walk request FSM ----------------
`ifdef WALK_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_pulse_q, tmo_pulse_d;
`else
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d  = state_q;
        served_d = served_q;
`ifdef WALK_TIMEOUT_EN
        tmo_pulse_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // walkLight already on means the crossing is being served.
                if (press) begin
                    state_d = walkLight ? SERVE : REQ;
                end
            end
            REQ: begin
                if (walkLight) begin
                    state_d = SERVE;
                    if (served_q != 8'hFF) begin
                        served_d = served_q + 8'd1;
                    end
                end
`ifdef WALK_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = IDLE;
                    tmo_pulse_d = 1'b1;
                end
`endif
            end
            SERVE: begin
                if (!walkLight) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef WALK_TIMEOUT_EN
    // Counts cycles already spent in REQ; zero on entry.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == REQ && state_d == REQ) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q   <= '0;
            tmo_pulse_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_pulse_q <= tmo_pulse_d;
        end
    end

    assign walk_timeout = tmo_pulse_q;
`else
    assign walk_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
        end
    end

    assign walkButton   = (state_q == REQ);
    assign Sensor       = deb_q[SNS];
    assign served_count = served_q;

endmodule
